// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the sub-word load/store unit:
//   - request size encodings (byte / half / word / illegal)
//   - FSM state enumeration
//   - access_fault(): flags misaligned or illegal-size requests
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // A request faults when its size is illegal or its byte offset is not
    // naturally aligned for that size. Bytes can never be misaligned.
    function automatic logic access_fault(input logic [1:0] size,
                                          input logic [1:0] offset);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = offset[0];
            SZ_WORD: fault = (offset != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for a little-endian 32-bit word.
//   word        in   32  word read from memory
//   offset      in   2   byte offset within the word (byte address [1:0])
//   size        in   2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed   in   1   sign-extend (1) or zero-extend (0) the loaded lane
//   store_data  in   32  right-justified store data
//   load_value  out  32  addressed lane, extended to 32 bits
//   store_word  out  32  word with the addressed lane replaced by store_data;
//                        for word size this is store_data itself
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [4:0]  bit_pos;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default at the top,
    // so no path through the case statements can leave a value held (latch).
    always_comb begin
        bit_pos    = {offset, 3'b000};
        byte_lane  = word[bit_pos +: 8];
        half_lane  = offset[1] ? word[31:16] : word[15:0];
        load_value = word;
        store_word = word;

        case (size)
            SZ_BYTE: begin
                load_value = {{24{is_signed & byte_lane[7]}}, byte_lane};
                store_word[bit_pos +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_value = {{16{is_signed & half_lane[15]}}, half_lane};
                if (offset[1]) begin
                    store_word[31:16] = store_data[15:0];
                end else begin
                    store_word[15:0] = store_data[15:0];
                end
            end
            default: begin
                load_value = word;
                store_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/lsu_subword_rmw.sv
// -----------------------------------------------------------------------------
// lsu_subword_rmw
// Load/store unit in front of a word-only data memory. Byte/half loads are
// extracted and extended from a full-word read; byte/half stores are done as
// read-modify-write. Misaligned or illegal-size requests complete with an
// error and never touch memory.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            loads: sign-extend when 1
//   req_addr              byte address (ADDR_W+2 bits)
//   req_wdata             right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_err              misaligned / illegal size, valid with resp_valid
//   resp_rdata            extended load data; 0 for stores and errors
//   mem_read, mem_write   memory strobes (state-decoded, killed by reset)
//   mem_addr              word address of the captured request
//   mem_wdata             word to write
//   mem_rdata             combinational read data from the memory
// -----------------------------------------------------------------------------
module lsu_subword_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e state, state_next;

    // Request captured at acceptance; the requester may change its inputs
    // afterwards.
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] load_value;
    logic [31:0] store_word;

    // Acceptance is decoded from state rather than req_ready so the output
    // decode below does not feed back into itself.
    assign accept    = req_valid && (state == IDLE);
    assign req_fault = access_fault(req_size, req_addr[1:0]);

    // NOTE: state and capture registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the capture registers are reset (not left undefined) so a fresh
    // DONE/READ decode after reset never sees X data on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_fault;
            end
            if (state == READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .word       (rdata_q),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .is_signed  (signed_q),
        .store_data (wdata_q),
        .load_value (load_value),
        .store_word (store_word)
    );

    // Next-state and output decode. Strobes depend on state only, and are
    // suppressed during reset so an abandoned RMW never reaches memory.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_fault) begin
                        state_next = DONE;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                mem_read   = !reset;
                state_next = we_q ? WRITE : DONE;
            end
            WRITE: begin
                mem_write  = !reset;
                state_next = DONE;
            end
            DONE: begin
                resp_valid = !reset;
                resp_err   = err_q;
                if (!err_q && !we_q) begin
                    resp_rdata = load_value;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr  = addr_q[ADDR_W+1:2];
    // Word stores pass straight through the lane module; sub-word stores
    // merge into the word latched during READ.
    assign mem_wdata = store_word;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
module tb_lsu_subword_rmw;

    localparam int ADDR_W = 7;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    lsu_subword_rmw #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-only memory seen by the DUT.
    logic [31:0] mem [WORDS];
    assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a word array plus the cycle numbers at which each
    // strobe and the response must appear, derived from the per-operation
    // latencies (load 2, SW 2, SB/SH 3, error 1).
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [WORDS];
    int          rd_c = -1, wr_c = -1, rsp_c = -1, idle_from = 0;
    int          w_idx = 0;
    logic [31:0] w_word = 0, exp_rdata = 0;
    logic        exp_err = 0;
    logic [6:0]  exp_addr = 0;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = i * 10;
            ref_mem[i] = i * 10;
        end
    end

    initial begin : model
        int e, off, idx;
        logic [31:0] v, mask;
        forever begin
            @(posedge clk);
            e = cyc; // cycle that just ended
            if (reset) begin
                idle_from = e + 1;
                rd_c = -1; wr_c = -1; rsp_c = -1;
            end else begin
                if (e == wr_c) ref_mem[w_idx] = w_word;
                if (req_valid && e >= idle_from) begin
                    off      = int'(req_addr[1:0]);
                    idx      = int'(req_addr[ADDR_W+1:2]);
                    exp_addr = req_addr[ADDR_W+1:2];
                    w_idx    = idx;
                    exp_err  = (req_size == 2'b11) ||
                               (req_size == 2'b01 && (off % 2) != 0) ||
                               (req_size == 2'b10 && off != 0);
                    exp_rdata = 0;
                    rd_c = -1; wr_c = -1;
                    if (exp_err) begin
                        rsp_c = e + 1;
                    end else if (!req_we) begin
                        rd_c  = e + 1;
                        rsp_c = e + 2;
                        v = ref_mem[idx] >> (8 * off);
                        if (req_size == 2'b00) begin
                            v = v & 32'hFF;
                            if (req_signed && v >= 32'h80) v = v | 32'hFFFF_FF00;
                        end else if (req_size == 2'b01) begin
                            v = v & 32'hFFFF;
                            if (req_signed && v >= 32'h8000) v = v | 32'hFFFF_0000;
                        end
                        exp_rdata = v;
                    end else if (req_size == 2'b10) begin
                        wr_c   = e + 1;
                        rsp_c  = e + 2;
                        w_word = req_wdata;
                    end else begin
                        rd_c  = e + 1;
                        wr_c  = e + 2;
                        rsp_c = e + 3;
                        mask  = ((req_size == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * off);
                        w_word = (ref_mem[idx] & ~mask) | ((req_wdata << (8 * off)) & mask);
                    end
                    idle_from = rsp_c + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus strobe/response monitors.
    int n_reads = 0, n_writes = 0, n_resp = 0, last_rd = -1, last_wr = -1;
    int resp_q[$];

    initial begin : compare
        int c;
        forever begin
            @(negedge clk);
            c = cyc;
            if (mem_read)  begin n_reads++;  last_rd = c; end
            if (mem_write) begin n_writes++; last_wr = c; end
            if (reset) begin
                check("strobes_in_reset", {30'b0, mem_read, mem_write}, 32'h0);
            end else begin
                check("req_ready",  req_ready,  c >= idle_from);
                check("mem_read",   mem_read,   c == rd_c);
                check("mem_write",  mem_write,  c == wr_c);
                check("resp_valid", resp_valid, c == rsp_c);
                if (c == rd_c || c == wr_c) check("mem_addr", mem_addr, exp_addr);
                if (c == wr_c) check("mem_wdata", mem_wdata, w_word);
                if (c == rsp_c) begin
                    check("resp_err",   resp_err,   exp_err);
                    check("resp_rdata", resp_rdata, exp_rdata);
                end
                if (resp_valid) begin
                    n_resp++;
                    resp_q.push_back(c);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed request helper: issues one request, returns accept cycle,
    // latency to resp_valid and the response fields.
    // ------------------------------------------------------------------
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [ADDR_W+1:0] addr, input logic [31:0] wd,
                         output int t_acc, output int lat,
                         output logic err, output logic [31:0] rd);
        int guard;
        @(posedge clk); #1;
        req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) fail("accept_timeout");
        t_acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; err = 1'b0; rd = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - t_acc;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
        if (lat < 0) fail("resp_timeout");
    endtask

    initial begin : stimulus
        int          t, lat, w0, r0, n0, guard;
        logic        err;
        logic [31:0] rd;
        int          bad;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_req_ready",  req_ready,  32'h1);
        check("rst_resp_valid", resp_valid, 32'h0);
        check("rst_resp_err",   resp_err,   32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);

        // Loads of word 25 = 250 = 0xFA.
        w0 = n_writes;
        issue(1'b0, 2'b00, 1'b1, 9'd100, 32'h0, t, lat, err, rd);
        check("lb_lat",   lat, 32'd2);
        check("lb_rdata", rd,  32'hFFFF_FFFA);
        issue(1'b0, 2'b00, 1'b0, 9'd100, 32'h0, t, lat, err, rd);
        check("lbu_rdata", rd, 32'h0000_00FA);
        check("load_no_write", n_writes - w0, 32'd0);

        // SB then readback.
        issue(1'b1, 2'b00, 1'b0, 9'd101, 32'hFFFF_FFAB, t, lat, err, rd);
        check("sb_lat",      lat,         32'd3);
        check("sb_read_at",  last_rd - t, 32'd1);
        check("sb_write_at", last_wr - t, 32'd2);
        check("sb_rdata",    rd,          32'h0);
        issue(1'b0, 2'b10, 1'b0, 9'd100, 32'h0, t, lat, err, rd);
        check("lw_after_sb", rd, 32'h0000_ABFA);

        // SH then readbacks.
        issue(1'b1, 2'b01, 1'b0, 9'd102, 32'h5555_1234, t, lat, err, rd);
        check("sh_lat", lat, 32'd3);
        issue(1'b0, 2'b01, 1'b1, 9'd102, 32'h0, t, lat, err, rd);
        check("lh_after_sh", rd, 32'h0000_1234);
        issue(1'b0, 2'b10, 1'b0, 9'd100, 32'h0, t, lat, err, rd);
        check("lw_after_sh", rd, 32'h1234_ABFA);

        // Errors.
        w0 = n_writes; r0 = n_reads;
        issue(1'b1, 2'b10, 1'b0, 9'h00A, 32'hDEAD_BEEF, t, lat, err, rd);
        check("sw_mis_err",   err, 32'h1);
        check("sw_mis_lat",   lat, 32'd1);
        check("sw_mis_rdata", rd,  32'h0);
        issue(1'b0, 2'b01, 1'b1, 9'h007, 32'h0, t, lat, err, rd);
        check("lh_mis_err", err, 32'h1);
        issue(1'b0, 2'b11, 1'b0, 9'h000, 32'h0, t, lat, err, rd);
        check("size11_err", err, 32'h1);
        check("err_no_strobe", (n_writes - w0) + (n_reads - r0), 32'd0);

        // Reset during the READ of an SB to word 5.
        w0 = n_writes; n0 = n_resp;
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 9'd20; req_wdata = 32'h0000_0077; req_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) fail("rst_accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_abort_ready", req_ready, 32'h1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_abort_no_write", n_writes - w0, 32'd0);
        check("rst_abort_word5",    mem[5],        32'd50);
        check("rst_abort_no_resp",  n_resp - n0,   32'd0);

        // Back-to-back: LW (2), SB (3), SW (2) with req_valid held high.
        resp_q.delete();
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 9'd100; req_wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            @(negedge clk);
            while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
            if (!req_ready) fail("b2b_accept_timeout");
            @(posedge clk); #1;
            if (i == 0) begin
                req_we = 1'b1; req_size = 2'b00; req_addr = 9'd8; req_wdata = 32'h0000_00C3;
            end else if (i == 1) begin
                req_we = 1'b1; req_size = 2'b10; req_addr = 9'd12; req_wdata = 32'hCAFE_F00D;
            end else begin
                req_valid = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        check("b2b_resp_count", resp_q.size(), 32'd3);
        if (resp_q.size() == 3) begin
            check("b2b_gap_sb", resp_q[1] - resp_q[0], 32'd4);
            check("b2b_gap_sw", resp_q[2] - resp_q[1], 32'd3);
        end

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 59) == 0);
            req_valid  = ($urandom_range(0, 9) < 6);
            req_we     = $urandom_range(0, 1);
            req_size   = $urandom_range(0, 3);
            req_signed = $urandom_range(0, 1);
            req_addr   = $urandom_range(0, (4 * WORDS) - 1);
            if ($urandom_range(0, 3) != 0) begin
                if (req_size == 2'b01) req_addr[0]   = 1'b0;
                if (req_size == 2'b10) req_addr[1:0] = 2'b00;
            end
            req_wdata  = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        repeat (8) @(negedge clk);

        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_image", bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
